uart_tx_port: RTL and testbench

UART_TX_PORT -- requirements
Module: uart_tx_port

---
 rtl/uart_tx_port_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 51 +++++
 rtl/uart_tx_port.sv | 142 ++++++++++++++
 tb/tb_uart_tx_port.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_port_pkg.sv
// Shared peripheral constants for the UART transmit port: bus addresses,
// default bit timing and the transmitter state encoding.
package uart_tx_port_pkg;

  localparam int unsigned UART_BAUD_DIV_DEFAULT  = 2604;
  localparam logic [31:0] UART_DATA_ADDR_DEFAULT = 32'h7f30;
  localparam logic [31:0] UART_STAT_ADDR_DEFAULT = 32'h7f34;

  localparam int unsigned UART_FIFO_DEPTH = 4;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Status word: bit1 = nothing queued and line idle, bit0 = room for a write.
  function automatic logic [31:0] status_word(input logic drained, input logic has_room);
    return {30'b0, drained, has_room};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// 4x8 transmit FIFO with a combinational head so the transmitter can pop
// straight into its shift register on the same edge.
module uart_tx_fifo
  import uart_tx_port_pkg::*;
(
  input  logic       clk_in,
  input  logic       sys_rstn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  logic [7:0] mem_reg [0:UART_FIFO_DEPTH-1];
  logic [1:0] wr_ptr_reg;
  logic [1:0] rd_ptr_reg;
  logic [2:0] count_reg;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (count_reg == 3'd4);
  assign empty   = (count_reg == 3'd0);
  assign head    = mem_reg[rd_ptr_reg];
  // Fullness/emptiness are the pre-edge values, so a push into a full FIFO is
  // dropped even if a pop happens on the same edge.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: bus decode, 4-deep byte queue, and a
// registered serial line driven by a start/data/stop state machine.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = UART_BAUD_DIV_DEFAULT,
  parameter logic [31:0] DATA_ADDR = UART_DATA_ADDR_DEFAULT,
  parameter logic [31:0] STAT_ADDR = UART_STAT_ADDR_DEFAULT
) (
  input  logic        clk_in,
  input  logic        sys_rstn,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        uart_txd,
  output logic        tx_busy
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e        state_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       last_byte_reg;
  logic             txd_reg;
  logic             busy_reg;

  logic       push_req;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       baud_wrap;
  logic       unused_bus_bits;

  assign unused_bus_bits = ^{m_data_wdata[31:8], m_data_byteen[3:1]};

  assign push_req  = (m_data_addr == DATA_ADDR) & m_data_byteen[0];
  assign baud_wrap = (baud_cnt_reg == CNT_LAST);
  assign fifo_pop  = ~fifo_empty &
                     ((state_reg == ST_IDLE) | ((state_reg == ST_STOP) & baud_wrap));

  uart_tx_fifo u_fifo (
    .clk_in    (clk_in),
    .sys_rstn  (sys_rstn),
    .push      (push_req),
    .push_data (m_data_wdata[7:0]),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      last_byte_reg <= 8'd0;
    end else if (push_req && !fifo_full) begin
      last_byte_reg <= m_data_wdata[7:0];
    end
  end

  // A queued byte never waits in IDLE for more than one edge, so busy tracks
  // the frame itself and drops only when the machine returns to IDLE.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      baud_cnt_reg <= baud_wrap ? '0 : baud_cnt_reg + CNT_ONE;
      case (state_reg)
        ST_IDLE: begin
          baud_cnt_reg <= '0;
          if (!fifo_empty) begin
            state_reg <= ST_START;
            shift_reg <= fifo_head;
            txd_reg   <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_wrap) begin
            state_reg   <= ST_DATA;
            bit_cnt_reg <= 3'd0;
            txd_reg     <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
          end
        end
        ST_DATA: begin
          if (baud_wrap) begin
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= ST_STOP;
              txd_reg   <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              txd_reg     <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
            end
          end
        end
        ST_STOP: begin
          if (baud_wrap) begin
            if (!fifo_empty) begin
              state_reg <= ST_START;
              shift_reg <= fifo_head;
              txd_reg   <= 1'b0;
            end else begin
              state_reg <= ST_IDLE;
              txd_reg   <= 1'b1;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          txd_reg   <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    m_data_rdata = 32'd0;
    if (m_data_addr == STAT_ADDR) begin
      m_data_rdata = status_word(fifo_empty & (state_reg == ST_IDLE), ~fifo_full);
    end else if (m_data_addr == DATA_ADDR) begin
      m_data_rdata = {24'd0, last_byte_reg};
    end
  end

  assign uart_txd = txd_reg;
  assign tx_busy  = busy_reg;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port at BAUD_DIV=4: a queue-and-timeline model is
// compared every cycle, with literal frame expectations for each scenario.
module tb_uart_tx_port;

  localparam int          B         = 4;
  localparam logic [31:0] DATA_ADDR = 32'h7f30;
  localparam logic [31:0] STAT_ADDR = 32'h7f34;

  logic        clk_in;
  logic        sys_rstn;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic        uart_txd;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  uart_tx_port #(.BAUD_DIV(B), .DATA_ADDR(DATA_ADDR), .STAT_ADDR(STAT_ADDR)) dut (
    .clk_in        (clk_in),
    .sys_rstn      (sys_rstn),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata),
    .uart_txd      (uart_txd),
    .tx_busy       (tx_busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue plus "position within the current frame" in cycles.
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'd0;
  logic [7:0] m_last = 8'd0;
  bit         m_push;

  always @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_cur    = 8'd0;
      m_last   = 8'd0;
    end else begin
      m_push = (m_data_addr == DATA_ADDR) && m_data_byteen[0] && (mq.size() < 4);
      if (m_active) begin
        m_pos++;
        if (m_pos == 10 * B) begin
          if (mq.size() > 0) begin
            m_cur = mq.pop_front();
            m_pos = 0;
          end else begin
            m_active = 1'b0;
          end
        end
      end else if (mq.size() > 0) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (m_push) begin
        mq.push_back(m_data_wdata[7:0]);
        m_last = m_data_wdata[7:0];
      end
    end
  end

  function automatic logic exp_txd();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / B;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (m_data_addr == STAT_ADDR)
      return {30'b0, (mq.size() == 0) && !m_active, mq.size() != 4};
    if (m_data_addr == DATA_ADDR)
      return {24'd0, m_last};
    return 32'd0;
  endfunction

  always @(negedge clk_in) begin
    chk("model_txd", {31'd0, uart_txd}, {31'd0, exp_txd()});
    chk("model_busy", {31'd0, tx_busy}, {31'd0, m_active});
    chk("model_rdata", m_data_rdata, exp_rdata());
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic cyc_write(input logic [7:0] d);
    m_data_addr   = DATA_ADDR;
    m_data_wdata  = {24'hABCDEF, d};
    m_data_byteen = 4'b0001;
    tick();
  endtask

  task automatic bus_idle();
    m_data_addr   = STAT_ADDR;
    m_data_wdata  = 32'd0;
    m_data_byteen = 4'b0000;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [9:0] frame_a5;
  int         busy_cnt;
  int         first_low;
  int         low_cnt;

  initial begin
    frame_a5      = 10'b1_1010_0101_0;
    sys_rstn      = 1'b0;
    m_data_addr   = STAT_ADDR;
    m_data_wdata  = 32'd0;
    m_data_byteen = 4'b0000;
    tick(3);
    chk("reset_status", m_data_rdata, 32'h3);
    chk("reset_txd", {31'd0, uart_txd}, 32'd1);
    chk("reset_busy", {31'd0, tx_busy}, 32'd0);
    sys_rstn = 1'b1;
    tick(2);

    // Single byte 0xA5 from idle.
    cyc_write(8'hA5);
    bus_idle();
    chk("push_edge_txd", {31'd0, uart_txd}, 32'd1);
    chk("push_edge_busy", {31'd0, tx_busy}, 32'd0);
    busy_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      chk($sformatf("a5_txd[%0d]", i), {31'd0, uart_txd},
          {31'd0, (i < 40) ? frame_a5[i / B] : 1'b1});
      busy_cnt += int'(tx_busy);
    end
    chk("a5_busy_cycles", busy_cnt, 40);

    // Back-to-back 0x01 then 0x80.
    cyc_write(8'h01);
    cyc_write(8'h80);
    bus_idle();
    busy_cnt  = 0;
    first_low = -1;
    for (int i = 0; i < 100; i++) begin
      if (!tx_busy && first_low < 0) first_low = i;
      busy_cnt += int'(tx_busy);
      tick();
    end
    chk("b2b_busy_cycles", busy_cnt, 80);
    chk("b2b_first_idle", first_low, 80);

    // Overflow: 0x10..0x15 on consecutive cycles, 0x15 dropped.
    for (int i = 0; i < 6; i++) cyc_write(8'h10 + 8'(i));
    bus_idle();
    chk("full_status", m_data_rdata, 32'h0);
    m_data_addr = DATA_ADDR;
    #1;
    chk("last_byte_after_overflow", m_data_rdata, 32'h14);
    bus_idle();
    busy_cnt = 0;
    for (int i = 0; i < 220; i++) begin
      busy_cnt += int'(tx_busy);
      tick();
    end
    chk("overflow_busy_cycles", busy_cnt, 196);
    chk("overflow_drained_status", m_data_rdata, 32'h3);

    // Byte-enable and address filtering.
    m_data_addr = DATA_ADDR; m_data_wdata = 32'h77; m_data_byteen = 4'b1110;
    tick();
    m_data_addr = 32'h7f50;  m_data_wdata = 32'h66; m_data_byteen = 4'b1111;
    #1;
    chk("other_addr_rdata", m_data_rdata, 32'h0);
    tick();
    bus_idle();
    chk("filter_status", m_data_rdata, 32'h3);
    m_data_addr = DATA_ADDR;
    #1;
    chk("filter_last_byte", m_data_rdata, 32'h14);
    bus_idle();
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      busy_cnt += int'(tx_busy);
      tick();
    end
    chk("filter_busy_cycles", busy_cnt, 0);

    // Reset in the middle of the third data bit of 0xC3 (that bit is 0).
    cyc_write(8'hC3);
    bus_idle();
    tick(14);
    chk("pre_reset_txd", {31'd0, uart_txd}, 32'd0);
    sys_rstn = 1'b0;
    #1;
    chk("in_reset_txd", {31'd0, uart_txd}, 32'd1);
    chk("in_reset_busy", {31'd0, tx_busy}, 32'd0);
    chk("in_reset_status", m_data_rdata, 32'h3);
    tick(2);
    sys_rstn = 1'b1;
    #1;
    chk("post_reset_status", m_data_rdata, 32'h3);
    low_cnt  = 0;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      low_cnt  += int'(!uart_txd);
      busy_cnt += int'(tx_busy);
      tick();
    end
    chk("post_reset_low_bits", low_cnt, 0);
    chk("post_reset_busy", busy_cnt, 0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
